// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor built from one full-subtractor cell

module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    logic t1;
    logic t2;
    logic t3;
    logic d_bit;
    logic bout;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Full-subtractor slice: two half-subtractors plus an OR of their borrows.
    half_subtractor u_hs_op (
        .x  (sa[0]),
        .y  (sb[0]),
        .d  (t1),
        .bo (t2)
    );

    half_subtractor u_hs_borrow (
        .x  (t1),
        .y  (borrow),
        .d  (d_bit),
        .bo (t3)
    );

    assign bout = t2 | t3;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured when no subtraction is in flight.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status flags are registered copies of the upcoming state so nothing is combinational from inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
        end
    end

    // Operand shifters, result accumulator and output capture on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            sa     <= a;
            sb     <= b;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            res    <= {d_bit, res[WIDTH-1:1]};
            borrow <= bout;
            if (last_bit) begin
                diff       <= {d_bit, res[WIDTH-1:1]};
                borrow_out <= bout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor

module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned r;
        r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
        return r[W-1:0];
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return int'(x) < int'(y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and reports what was observed; callers do the comparisons.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] d, output logic bo,
                          output int lat, output int bcyc, output logic bad);
        logic [W-1:0] prev_d;
        logic         prev_bo;
        prev_d  = diff;
        prev_bo = borrow_out;
        bad     = 1'b0;
        lat     = -1;
        bcyc    = 0;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int n = 0; n < 20; n++) begin
            if (busy) bcyc++;
            if (busy && done) bad = 1'b1;
            if (done) begin
                lat = n;
                break;
            end
            if (diff !== prev_d || borrow_out !== prev_bo) bad = 1'b1;
            tick();
        end
        d  = diff;
        bo = borrow_out;
        tick();
        if (done) bad = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a = 8'h35;
        b = 8'h12;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b diff=%h bo=%b expected 0 0 00 0", busy, done, diff, borrow_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        int           bcyc;
        logic         bad;
        run_op(x, y, d, bo, lat, bcyc, bad);
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL %s_latency got %0d expected %0d", name, lat, W);
        end
        checks++;
        if (bcyc !== W) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d expected %0d", name, bcyc, W);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL %s_protocol got bad=%b expected 0 (overlap, early output change or long done)", name, bad);
        end
        checks++;
        if (d !== ref_diff(x, y)) begin
            errors++;
            $display("FAIL %s_diff %h-%h got %h expected %h", name, x, y, d, ref_diff(x, y));
        end
        checks++;
        if (bo !== ref_borrow(x, y)) begin
            errors++;
            $display("FAIL %s_borrow %h-%h got %b expected %b", name, x, y, bo, ref_borrow(x, y));
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] xs [5] = '{8'h35, 8'h12, 8'h00, 8'hFF, 8'h80};
        logic [W-1:0] ys [5] = '{8'h12, 8'h35, 8'h01, 8'hFF, 8'h7F};
        for (int i = 0; i < 5; i++) begin
            check_op($sformatf("directed%0d", i), xs[i], ys[i]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_op($sformatf("random%0d", i), W'($urandom), W'($urandom));
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] opa [$];
        logic [W-1:0] opb [$];
        int           results = 0;
        for (int t = 0; t < 36; t++) begin
            a = W'($urandom);
            b = W'($urandom);
            opa.push_back(a);
            opb.push_back(b);
            start = 1'b1;
            tick();
            checks++;
            if (done !== ((t % (W + 1)) == W)) begin
                errors++;
                $display("FAIL b2b_done_t%0d got %b expected %b", t, done, (t % (W + 1)) == W);
            end
            if (done && t >= W) begin
                results++;
                checks++;
                if (diff !== ref_diff(opa[t-W], opb[t-W]) || borrow_out !== ref_borrow(opa[t-W], opb[t-W])) begin
                    errors++;
                    $display("FAIL b2b_result_t%0d got %h/%b expected %h/%b", t, diff, borrow_out,
                             ref_diff(opa[t-W], opb[t-W]), ref_borrow(opa[t-W], opb[t-W]));
                end
            end
        end
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (results !== 4) begin
            errors++;
            $display("FAIL b2b_count got %0d expected 4", results);
        end
    endtask

    task automatic test_start_during_run();
        int n_done = 0;
        int first  = -1;
        a = 8'h35;
        b = 8'h12;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 3; n < 25; n++) begin
            if (done) begin
                n_done++;
                if (first < 0) begin
                    first = n;
                    checks++;
                    if (diff !== 8'h23 || borrow_out !== 1'b0) begin
                        errors++;
                        $display("FAIL ignore_start_result got %h/%b expected 23/0", diff, borrow_out);
                    end
                end
            end
            tick();
        end
        checks++;
        if (n_done !== 1 || first !== W) begin
            errors++;
            $display("FAIL ignore_start_pulses got count=%0d at=%0d expected count=1 at=%0d", n_done, first, W);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_done = 0;
        a = 8'hA7;
        b = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b diff=%h bo=%b expected 0 0 00 0", busy, done, diff, borrow_out);
        end
        for (int n = 0; n < 12; n++) begin
            if (done || busy) n_done++;
            tick();
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL midrun_no_done got %0d active cycles expected 0", n_done);
        end
        check_op("after_reset", 8'h12, 8'h35);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_directed();
        test_start_during_run();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
